sync_fifo_prog: RTL and testbench

Parametrised single-clock FIFO: the next generation of the team's synchronous FIFO. It adds non-power-of-two depth with explicit pointer wrap, a selectable read mode (standard or first-word-fall-through), runtime-programmable almost-full and almost-empty thresholds, and sticky overflow and underflow error flags with a clear input. It sits between single-clock producer and consumer datapaths, and replaces the fixed-threshold FIFO wherever thresholds or FWFT are needed.

---
 rtl/sync_fifo_prog.sv | 199 +++++++++++++++++++
 tb/tb_sync_fifo_prog.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with arbitrary depth, standard or
// first-word-fall-through read, programmable almost-full/almost-empty
// thresholds and sticky overflow/underflow flags.
module sync_fifo_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int FWFT       = 0,
  parameter int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  aclr_n,
  input  logic                  sclr_n,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [CW-1:0]         af_thresh,
  input  logic [CW-1:0]         ae_thresh,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic [CW-1:0]         usedw
);

  localparam int              PW       = $clog2(DEPTH);
  localparam logic [PW-1:0]   PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);

  // Pointer advance with explicit wrap so any depth works.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    if (p == PTR_LAST) begin
      r = {PW{1'b0}};
    end else begin
      r = p + PW'(1);
    end
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         usedw_q, usedw_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dval_q, dval_d;
  logic                  full_q, full_d;
  logic                  afull_q, afull_d;
  logic                  empty_q, empty_d;
  logic                  aempty_q, aempty_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic [CW-1:0]         mem_cnt_s;
  logic                  load_s;
  logic [DATA_WIDTH-1:0] head_s;

  // Acceptance uses the registered flags; the clear blocks any transfer.
  assign wr_acc_s  = wr_en && !full_q && sclr_n;
  assign rd_acc_s  = rd_en && !empty_q && sclr_n;
  // Words still in memory (in FWFT mode the word in dout is not counted here).
  assign mem_cnt_s = usedw_q - CW'(dval_q);
  assign head_s    = mem_q[rd_ptr_q];
  // FWFT prefetch: refill dout whenever it is free or being acknowledged.
  assign load_s    = (FWFT != 0) && (!dval_q || rd_acc_s) && (mem_cnt_s != {CW{1'b0}});

  // Next-state logic for pointers, count, read data, status and error flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    dout_d   = dout_q;
    dval_d   = dval_q;
    full_d   = full_q;
    afull_d  = afull_q;
    empty_d  = empty_q;
    aempty_d = aempty_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (!sclr_n) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      usedw_d  = {CW{1'b0}};
      dout_d   = {DATA_WIDTH{1'b0}};
      dval_d   = 1'b0;
      full_d   = 1'b0;
      afull_d  = 1'b0;
      empty_d  = 1'b1;
      aempty_d = 1'b1;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_d = next_ptr(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      case ({wr_acc_s, rd_acc_s})
        2'b10:   usedw_d = usedw_q + CW'(1);
        2'b01:   usedw_d = usedw_q - CW'(1);
        default: usedw_d = usedw_q;
      endcase

      if (FWFT != 0) begin
        if (load_s) begin
          dout_d   = head_s;
          rd_ptr_d = next_ptr(rd_ptr_q);
          dval_d   = 1'b1;
        end else if (rd_acc_s) begin
          dval_d   = 1'b0;
        end else begin
          dval_d   = dval_q;
        end
        empty_d = !dval_d;
      end else begin
        if (rd_acc_s) begin
          dout_d   = head_s;
          rd_ptr_d = next_ptr(rd_ptr_q);
        end else begin
          dout_d   = dout_q;
        end
        empty_d = (usedw_d == {CW{1'b0}});
      end

      full_d   = (usedw_d == CNT_FULL);
      afull_d  = (usedw_d >= af_thresh);
      aempty_d = (usedw_d <= ae_thresh);

      // Set wins over clear for both sticky error flags.
      if (wr_en && full_q) begin
        ovf_d = 1'b1;
      end else if (clr_err) begin
        ovf_d = 1'b0;
      end else begin
        ovf_d = ovf_q;
      end
      if (rd_en && empty_q) begin
        unf_d = 1'b1;
      end else if (clr_err) begin
        unf_d = 1'b0;
      end else begin
        unf_d = unf_q;
      end
    end
  end

  // State registers with asynchronous clear to the idle/empty state.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      usedw_q  <= {CW{1'b0}};
      dout_q   <= {DATA_WIDTH{1'b0}};
      dval_q   <= 1'b0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      dout_q   <= dout_d;
      dval_q   <= dval_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage array; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout         = dout_q;
  assign full         = full_q;
  assign almost_full  = afull_q;
  assign empty        = empty_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign usedw        = usedw_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench for sync_fifo_prog: a DEPTH=5 standard-mode instance (a)
// and a DEPTH=5 FWFT instance (b), driven with directed vectors.
module tb_sync_fifo_prog;

  logic clk = 1'b0;
  logic aclr_n, sclr_n;

  logic [7:0] din_a, dout_a, din_b, dout_b;
  logic       wr_en_a, rd_en_a, clr_a, wr_en_b, rd_en_b, clr_b;
  logic [2:0] af_a, ae_a, af_b, ae_b, usedw_a, usedw_b;
  logic       full_a, afull_a, empty_a, aempty_a, ovf_a, unf_a;
  logic       full_b, afull_b, empty_b, aempty_b, ovf_b, unf_b;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic       pend_a = 1'b0;

  sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0)) dut_a (
    .clk(clk), .aclr_n(aclr_n), .sclr_n(sclr_n), .din(din_a), .wr_en(wr_en_a),
    .rd_en(rd_en_a), .af_thresh(af_a), .ae_thresh(ae_a), .clr_err(clr_a),
    .dout(dout_a), .full(full_a), .almost_full(afull_a), .empty(empty_a),
    .almost_empty(aempty_a), .overflow(ovf_a), .underflow(unf_a), .usedw(usedw_a));

  sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(1)) dut_b (
    .clk(clk), .aclr_n(aclr_n), .sclr_n(sclr_n), .din(din_b), .wr_en(wr_en_b),
    .rd_en(rd_en_b), .af_thresh(af_b), .ae_thresh(ae_b), .clr_err(clr_b),
    .dout(dout_b), .full(full_b), .almost_full(afull_b), .empty(empty_b),
    .almost_empty(aempty_b), .overflow(ovf_b), .underflow(unf_b), .usedw(usedw_b));

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus on instance a; p pushes the expected read word e.
  task automatic op_a(input logic w, input logic [7:0] d, input logic r,
                      input logic p, input logic [7:0] e);
    @(negedge clk);
    wr_en_a = w; din_a = d; rd_en_a = r;
    if (p) q_a.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus on instance b; p pushes the expected head word e.
  task automatic op_b(input logic w, input logic [7:0] d, input logic r,
                      input logic p, input logic [7:0] e);
    @(negedge clk);
    wr_en_b = w; din_b = d; rd_en_b = r;
    if (p) q_b.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_chk_a(input string tag);
    check({tag, " dout_a"}, dout_a, 8'h00);
    check({tag, " usedw_a"}, usedw_a, 3'd0);
    check({tag, " full_a"}, full_a, 1'b0);
    check({tag, " afull_a"}, afull_a, 1'b0);
    check({tag, " empty_a"}, empty_a, 1'b1);
    check({tag, " aempty_a"}, aempty_a, 1'b1);
    check({tag, " ovf_a"}, ovf_a, 1'b0);
    check({tag, " unf_a"}, unf_a, 1'b0);
  endtask

  // Monitor: standard-mode data one edge after an accepted read; FWFT head
  // word checked while it is being acknowledged.
  always begin
    @(negedge clk);
    #1;
    if (pend_a) begin
      if (q_a.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL rd_a: got 0x%0h, expected no read", dout_a);
      end else begin
        check("rd_a data", dout_a, q_a.pop_front());
      end
    end
    pend_a = rd_en_a && !empty_a && sclr_n && aclr_n;
    if (rd_en_b && !empty_b && sclr_n && aclr_n) begin
      if (q_b.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL rd_b: got 0x%0h, expected no ack", dout_b);
      end else begin
        check("rd_b head", dout_b, q_b.pop_front());
      end
    end
  end

  // Directed stimulus.
  initial begin
    aclr_n = 1'b0; sclr_n = 1'b1;
    din_a = 8'h00; wr_en_a = 1'b0; rd_en_a = 1'b0; clr_a = 1'b0; af_a = 3'd4; ae_a = 3'd1;
    din_b = 8'h00; wr_en_b = 1'b0; rd_en_b = 1'b0; clr_b = 1'b0; af_b = 3'd4; ae_b = 3'd1;
    #12;
    reset_chk_a("por");
    check("por empty_b", empty_b, 1'b1);
    check("por usedw_b", usedw_b, 3'd0);
    @(negedge clk);
    aclr_n = 1'b1;

    // Fill to full, then overflow.
    for (int k = 1; k <= 5; k++) op_a(1'b1, 8'(k), 1'b0, 1'b0, 8'h00);
    check("fill usedw", usedw_a, 3'd5);
    check("fill full", full_a, 1'b1);
    check("fill afull", afull_a, 1'b1);
    check("fill empty", empty_a, 1'b0);
    op_a(1'b1, 8'd6, 1'b0, 1'b0, 8'h00);
    check("ovf set", ovf_a, 1'b1);
    check("ovf usedw", usedw_a, 3'd5);
    clr_a = 1'b1;
    op_a(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    clr_a = 1'b0;
    check("ovf clr", ovf_a, 1'b0);
    // Read and write at full: write rejected.
    op_a(1'b1, 8'd7, 1'b1, 1'b1, 8'd1);
    check("rw full ovf", ovf_a, 1'b1);
    check("rw full usedw", usedw_a, 3'd4);
    check("rw full full", full_a, 1'b0);
    for (int k = 2; k <= 5; k++) op_a(1'b0, 8'h00, 1'b1, 1'b1, 8'(k));
    check("drain usedw", usedw_a, 3'd0);
    check("drain empty", empty_a, 1'b1);
    check("drain aempty", aempty_a, 1'b1);

    // Wrap: 12 words through two pointer wraps, usedw held at 3.
    for (int k = 0; k < 3; k++) op_a(1'b1, 8'h10 + 8'(k), 1'b0, 1'b0, 8'h00);
    check("wrap usedw3", usedw_a, 3'd3);
    for (int i = 0; i < 9; i++) begin
      op_a(1'b1, 8'h13 + 8'(i), 1'b1, 1'b1, 8'h10 + 8'(i));
      check("rw usedw", usedw_a, 3'd3);
      check("rw full", full_a, 1'b0);
    end
    for (int k = 0; k < 3; k++) op_a(1'b0, 8'h00, 1'b1, 1'b1, 8'h19 + 8'(k));
    check("wrap end usedw", usedw_a, 3'd0);

    // Underflow and error clear.
    op_a(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    check("unf set", unf_a, 1'b1);
    check("unf usedw", usedw_a, 3'd0);
    clr_a = 1'b1;
    op_a(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    clr_a = 1'b0;
    check("unf set wins", unf_a, 1'b1);
    clr_a = 1'b1;
    op_a(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    clr_a = 1'b0;
    check("unf clr", unf_a, 1'b0);

    // Programmable thresholds.
    af_a = 3'd3;
    op_a(1'b1, 8'h31, 1'b0, 1'b0, 8'h00);
    check("th w1 aempty", aempty_a, 1'b1);
    check("th w1 afull", afull_a, 1'b0);
    op_a(1'b1, 8'h32, 1'b0, 1'b0, 8'h00);
    check("th w2 aempty", aempty_a, 1'b0);
    check("th w2 afull", afull_a, 1'b0);
    op_a(1'b1, 8'h33, 1'b0, 1'b0, 8'h00);
    check("th w3 afull", afull_a, 1'b1);
    af_a = 3'd4;
    op_a(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    check("th af4 afull", afull_a, 1'b0);
    check("th af4 usedw", usedw_a, 3'd3);

    // Synchronous clear discards contents and blocks the concurrent write.
    sclr_n = 1'b0;
    op_a(1'b1, 8'h40, 1'b0, 1'b0, 8'h00);
    sclr_n = 1'b1;
    check("sclr usedw", usedw_a, 3'd0);
    check("sclr empty", empty_a, 1'b1);
    check("sclr aempty", aempty_a, 1'b1);

    // Asynchronous clear mid-stream.
    op_a(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    op_a(1'b1, 8'h41, 1'b0, 1'b0, 8'h00);
    op_a(1'b1, 8'h42, 1'b0, 1'b0, 8'h00);
    op_a(1'b0, 8'h00, 1'b1, 1'b1, 8'h41);
    op_a(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    check("pre-aclr unf", unf_a, 1'b1);
    @(negedge clk);
    #2;
    aclr_n = 1'b0;
    #1;
    reset_chk_a("aclr");
    #1;
    aclr_n = 1'b1;
    op_a(1'b1, 8'h44, 1'b0, 1'b0, 8'h00);
    op_a(1'b0, 8'h00, 1'b1, 1'b1, 8'h44);
    op_a(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    check("post-aclr usedw", usedw_a, 3'd0);

    // FWFT latency.
    op_b(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
    check("fwft N usedw", usedw_b, 3'd1);
    check("fwft N empty", empty_b, 1'b1);
    op_b(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    check("fwft N+1 empty", empty_b, 1'b0);
    check("fwft N+1 dout", dout_b, 8'hA5);
    op_b(1'b0, 8'h00, 1'b1, 1'b1, 8'hA5);
    check("fwft ack empty", empty_b, 1'b1);
    check("fwft ack usedw", usedw_b, 3'd0);

    // FWFT fill, overflow, drain.
    for (int k = 0; k < 5; k++) op_b(1'b1, 8'hC1 + 8'(k), 1'b0, 1'b0, 8'h00);
    check("fwft full", full_b, 1'b1);
    check("fwft usedw5", usedw_b, 3'd5);
    op_b(1'b1, 8'hC6, 1'b0, 1'b0, 8'h00);
    check("fwft ovf", ovf_b, 1'b1);
    for (int k = 0; k < 5; k++) op_b(1'b0, 8'h00, 1'b1, 1'b1, 8'hC1 + 8'(k));
    check("fwft drain empty", empty_b, 1'b1);
    check("fwft drain usedw", usedw_b, 3'd0);
    op_b(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    check("fwft unf", unf_b, 1'b1);
    op_b(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    op_b(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

    check("scoreboard a left", q_a.size(), 32'd0);
    check("scoreboard b left", q_b.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
